// File: rtl/dbus_pkg.sv
// Shared constants for the data-bus responder: MMIO register offsets,
// STATUS bit positions and the address region decode.
package dbus_pkg;

  localparam logic [1:0] OFF_CONSOLE_TX = 2'd0;
  localparam logic [1:0] OFF_STATUS     = 2'd1;
  localparam logic [1:0] OFF_TIMER      = 2'd2;
  localparam logic [1:0] OFF_SCRATCH    = 2'd3;

  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVF       = 2;
  localparam int STAT_COUNT_LSB = 8;

  localparam logic [3:0] RAM_SEL = 4'h0;

  typedef enum logic [1:0] {
    REGION_NONE = 2'd0,
    REGION_RAM  = 2'd1,
    REGION_MMIO = 2'd2
  } region_e;

  function automatic region_e decode_region(input logic [3:0] top_nibble,
                                            input logic [3:0] mmio_sel);
    if (top_nibble == RAM_SEL)       return REGION_RAM;
    else if (top_nibble == mmio_sel) return REGION_MMIO;
    else                             return REGION_NONE;
  endfunction

endpackage

// File: rtl/dbus_responder_sync_fifo.sv
// Small synchronous FIFO with a combinational head output; a push into a
// full FIFO is still taken when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [AW:0]      count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_CNT);
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/dbus_responder.sv
// Data-port responder: word RAM plus MMIO console FIFO, status, timer and
// scratch register, all with one-cycle registered read data.
module dbus_responder
  import dbus_pkg::*;
#(
  parameter int         RAM_AW   = 12,
  parameter int         FIFO_AW  = 3,
  parameter logic [3:0] MMIO_SEL = 4'hF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_data_w,
  input  logic        d_data_we,
  output logic [31:0] d_data_r,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  region_e           region;
  logic [1:0]        offset;
  logic [RAM_AW-1:0] ram_idx;
  logic              ram_we, mmio_we;
  logic              unused_addr_bits;

  assign region  = decode_region(d_addr[31:28], MMIO_SEL);
  assign offset  = d_addr[3:2];
  assign ram_idx = d_addr[RAM_AW+1:2];
  assign ram_we  = (region == REGION_RAM)  && d_data_we;
  assign mmio_we = (region == REGION_MMIO) && d_data_we;
  assign unused_addr_bits = ^{d_addr[27:RAM_AW+2], d_addr[1:0]};

  // RAM: read-first, no reset, so it maps onto block RAM.
  logic [31:0] ram_q [1 << RAM_AW];
  logic [31:0] ram_rd_q;

  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_idx] <= d_data_w;
    ram_rd_q <= ram_q[ram_idx];
  end

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FIFO_AW:0] fifo_count;

  assign fifo_push = mmio_we && (offset == OFF_CONSOLE_TX);
  assign fifo_pop  = tx_valid && tx_ready;
  assign tx_valid  = !fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (fifo_push),
    .push_data_i (d_data_w[7:0]),
    .pop_i       (fifo_pop),
    .head_o      (tx_data),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  logic        ovf_q, ovf_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] status_word;
  logic [31:0] mmio_rd_q, mmio_rd_d;
  logic        ram_sel_q;

  always_comb begin
    status_word = '0;
    status_word[STAT_EMPTY] = fifo_empty;
    status_word[STAT_FULL]  = fifo_full;
    status_word[STAT_OVF]   = ovf_q;
    status_word[STAT_COUNT_LSB +: FIFO_AW+1] = fifo_count;
  end

  // A rejected push sets overflow even when software clears it that cycle.
  always_comb begin
    ovf_d = ovf_q;
    if (fifo_push && fifo_full && !fifo_pop)
      ovf_d = 1'b1;
    else if (mmio_we && (offset == OFF_STATUS) && d_data_w[STAT_OVF])
      ovf_d = 1'b0;
  end

  always_comb begin
    timer_d = timer_q + 32'd1;
    if (mmio_we && (offset == OFF_TIMER)) timer_d = d_data_w;
  end

  always_comb begin
    scratch_d = scratch_q;
    if (mmio_we && (offset == OFF_SCRATCH)) scratch_d = d_data_w;
  end

  always_comb begin
    mmio_rd_d = '0;
    if (region == REGION_MMIO) begin
      case (offset)
        OFF_STATUS:  mmio_rd_d = status_word;
        OFF_TIMER:   mmio_rd_d = timer_q;
        OFF_SCRATCH: mmio_rd_d = scratch_q;
        default:     mmio_rd_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q     <= 1'b0;
      timer_q   <= '0;
      scratch_q <= '0;
      mmio_rd_q <= '0;
      ram_sel_q <= 1'b0;
    end else begin
      ovf_q     <= ovf_d;
      timer_q   <= timer_d;
      scratch_q <= scratch_d;
      mmio_rd_q <= mmio_rd_d;
      ram_sel_q <= (region == REGION_RAM);
    end
  end

  // Clearing ram_sel_q on reset forces the in-flight read to 0.
  assign d_data_r = ram_sel_q ? ram_rd_q : mmio_rd_q;

endmodule
